// File: rtl/uart_tx_framer.sv
// uart_tx_framer: tick-paced UART serialiser with per-frame parity/stop selection and valid/ready intake
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bd_tick,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);
    localparam int CW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP2_LAST = CW'(2 * OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        tick_cnt, tick_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n, data_lat, data_lat_n;
    logic [1:0]           mode_lat, mode_lat_n;
    logic                 two_lat, two_lat_n, tx_n, done_n, bit_end, par;

    assign o_tx_ready = state == IDLE;
    assign o_tx_busy  = !o_tx_ready;
    // Parity uses the word as accepted, not the partially shifted copy
    assign par     = mode_lat == 2'b11 ? 1'b1 : mode_lat == 2'b10 ? ~^data_lat : ^data_lat;
    assign bit_end = i_bd_tick && tick_cnt == ((state == STOP && two_lat) ? STOP2_LAST : BIT_LAST);

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        data_lat_n = data_lat;
        mode_lat_n = mode_lat;
        two_lat_n  = two_lat;
        tx_n       = o_tx;
        done_n     = 1'b0;
        if (state == IDLE) begin
            if (i_tx_valid) begin
                data_lat_n = i_data;
                shift_n    = i_data;
                mode_lat_n = i_parity_mode;
                two_lat_n  = i_two_stop;
                tick_cnt_n = '0;
                bit_cnt_n  = '0;
                state_n    = START;
                tx_n       = 1'b0;
            end
        end else if (i_bd_tick) begin
            tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    START: begin
                        state_n = DATA;
                        tx_n    = shift[0];
                    end
                    DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            state_n = mode_lat != 2'b00 ? PARITY : STOP;
                            tx_n    = mode_lat != 2'b00 ? par : 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                            shift_n   = {1'b0, shift[DATA_BITS-1:1]};
                            tx_n      = shift[1];
                        end
                    end
                    PARITY: begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end
                    default: begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        done_n  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_lat  <= '0;
            mode_lat  <= '0;
            two_lat   <= 1'b0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            data_lat  <= data_lat_n;
            mode_lat  <= mode_lat_n;
            two_lat   <= two_lat_n;
            o_tx      <= tx_n;
            o_tx_done <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: random-stimulus bench checking the serial line against a tick-count frame model
module tb_uart_tx_framer;
    localparam int DB = 8;
    localparam int OS = 16;

    logic          i_clk = 1'b0;
    logic          i_reset, i_bd_tick, i_tx_valid, i_two_stop;
    logic          o_tx, o_tx_ready, o_tx_busy, o_tx_done;
    logic [DB-1:0] i_data;
    logic [1:0]    i_parity_mode;
    int            n_cmp = 0;
    int            n_err = 0;

    uart_tx_framer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_bd_tick(i_bd_tick), .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready), .i_data(i_data), .i_parity_mode(i_parity_mode),
        .i_two_stop(i_two_stop), .o_tx(o_tx), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level for bit index idx of a frame: start, data LSB first, optional parity, stop(s)
    function automatic logic exp_bit(input logic [DB-1:0] d, input logic [1:0] m, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (m != 2'b00 && idx == DB + 1) return m == 2'b11 ? 1'b1 : m == 2'b10 ? ~^d : ^d;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        i_tx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_bd_tick = 1'($urandom_range(0, 1));
            @(posedge i_clk); #1;
            check("idle_tx", o_tx, 1);
            check("idle_ready", o_tx_ready, 1);
            check("idle_done", o_tx_done, 0);
        end
    endtask

    // period 0 = random ticks; abort_at >= 0 resets the block after that many ticks
    task automatic run_frame(input logic [DB-1:0] d, input logic [1:0] m, input logic ts,
                             input int period, input int abort_at);
        int   total;
        int   cnt;
        int   cyc;
        logic t;
        total = OS * (1 + DB + (m != 2'b00 ? 1 : 0) + (ts ? 2 : 1));
        cnt = 0;
        cyc = 0;
        i_data = d;
        i_parity_mode = m;
        i_two_stop = ts;
        i_tx_valid = 1'b1;
        i_bd_tick = 1'b1;
        @(posedge i_clk); #1;
        i_tx_valid = 1'b0;
        check("accept_tx", o_tx, 0);
        check("accept_ready", o_tx_ready, 0);
        check("accept_busy", o_tx_busy, 1);
        check("accept_done", o_tx_done, 0);
        while (cnt < total && cyc < 20 * total) begin
            t = period == 0 ? 1'($urandom_range(0, 1)) : (cyc % period == period - 1);
            i_bd_tick = t;
            i_data = DB'($urandom);
            i_parity_mode = 2'($urandom);
            i_two_stop = 1'($urandom);
            i_tx_valid = 1'($urandom);
            @(posedge i_clk); #1;
            cyc++;
            if (t) cnt++;
            if (abort_at >= 0 && cnt == abort_at) begin
                i_tx_valid = 1'b0;
                #2 i_reset = 1'b1;
                #1;
                check("rst_tx", o_tx, 1);
                check("rst_ready", o_tx_ready, 1);
                check("rst_busy", o_tx_busy, 0);
                check("rst_done", o_tx_done, 0);
                @(posedge i_clk); #1;
                i_reset = 1'b0;
                idle(2 * OS);
                return;
            end
            if (cnt < total) begin
                check("tx", o_tx, exp_bit(d, m, cnt / OS));
                check("done_early", o_tx_done, 0);
                check("busy", o_tx_busy, 1);
            end
        end
        check("done", o_tx_done, 1);
        check("ready_end", o_tx_ready, 1);
        check("busy_end", o_tx_busy, 0);
        check("tx_end", o_tx, 1);
        if (period > 0) check("frame_clocks", cyc, total * period);
        i_tx_valid = 1'b0;
        i_bd_tick = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_bd_tick = 1'b0;
        i_tx_valid = 1'b0;
        i_data = '0;
        i_parity_mode = 2'b00;
        i_two_stop = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_tx", o_tx, 1);
        check("reset_ready", o_tx_ready, 1);
        check("reset_busy", o_tx_busy, 0);
        check("reset_done", o_tx_done, 0);
        i_reset = 1'b0;
        idle(4);
        run_frame(8'hA5, 2'b00, 1'b0, 1, -1);
        idle(3);
        run_frame(8'h03, 2'b01, 1'b0, 1, -1);
        idle(2);
        run_frame(8'h03, 2'b10, 1'b0, 1, -1);
        idle(2);
        run_frame(8'h00, 2'b11, 1'b0, 1, -1);
        idle(2);
        run_frame(8'hFF, 2'b00, 1'b1, 3, -1);
        idle(2);
        run_frame(8'h55, 2'b00, 1'b0, 1, -1);
        run_frame(8'h0F, 2'b00, 1'b0, 1, -1);
        idle(4);
        run_frame(DB'($urandom), 2'b00, 1'b0, 1, 4 * OS + OS / 2);
        run_frame(8'hC3, 2'b01, 1'b1, 1, -1);
        for (int i = 0; i < 20; i++) begin
            run_frame(DB'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
